// File: rtl/instr_pkg.sv
// Payload types carried across the CPU-NMCU chiplet link.
package instr_pkg;

    // Instruction issued by the CPU-side requester to the NMCU.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  dst;
        logic [15:0] operand;
    } instruction_t;

    // Response returned by the NMCU to the CPU side.
    typedef struct packed {
        logic [7:0]  tag;
        logic [1:0]  status;
        logic [31:0] data;
    } nmcu_cpu_resp_t;

endpackage

// File: rtl/nmcu_host_link.sv
// Host-side end of the CPU-NMCU link: command FIFO with credit-limited issue,
// response FIFO back to the requester, and a response watchdog.
module nmcu_host_link
    import instr_pkg::*;
#(
    parameter int unsigned CMD_DEPTH       = 4,
    parameter int unsigned RESP_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic                                   host_cmd_valid,
    output logic                                   host_cmd_ready,
    input  instruction_t                           host_cmd,

    output logic                                   cpu_instr_valid,
    input  logic                                   cpu_instr_ready,
    output instruction_t                           cpu_instruction,

    input  logic                                   nmcu_resp_valid,
    output logic                                   nmcu_resp_ready,
    input  nmcu_cpu_resp_t                         nmcu_response,

    output logic                                   host_resp_valid,
    input  logic                                   host_resp_ready,
    output nmcu_cpu_resp_t                         host_resp,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   timeout_err,
    output logic                                   stray_resp_err,
    input  logic                                   err_clr
);

    localparam int unsigned CAW = $clog2(CMD_DEPTH);
    localparam int unsigned RAW = $clog2(RESP_DEPTH);
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned WW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CAW:0]  CmdOne  = (CAW + 1)'(1);
    localparam logic [RAW:0]  RespOne = (RAW + 1)'(1);
    localparam logic [OW-1:0] OutOne  = OW'(1);
    localparam logic [OW-1:0] MaxOut  = OW'(MAX_OUTSTANDING);
    localparam logic [WW-1:0] WdOne   = WW'(1);
    localparam logic [WW-1:0] WdLimit = WW'(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    instruction_t   cmd_mem_q  [CMD_DEPTH];
    nmcu_cpu_resp_t resp_mem_q [RESP_DEPTH];

    logic [CAW:0]    cmd_wptr_q,  cmd_wptr_d;
    logic [CAW:0]    cmd_rptr_q,  cmd_rptr_d;
    logic [RAW:0]    resp_wptr_q, resp_wptr_d;
    logic [RAW:0]    resp_rptr_q, resp_rptr_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
    logic            timeout_err_q, timeout_err_d;
    logic            stray_err_q, stray_err_d;

    // ------------------------------------------------------------------
    // Derived status and handshakes
    // ------------------------------------------------------------------
    logic cmd_empty, cmd_full, resp_empty, resp_full;
    logic cmd_push, cmd_issue, resp_accept, resp_pop;
    logic out_zero, credit_ok, wd_reach;

    // FIFO status, handshakes and the externally visible outputs
    always_comb begin
        cmd_empty  = (cmd_wptr_q == cmd_rptr_q);
        cmd_full   = (cmd_wptr_q[CAW] != cmd_rptr_q[CAW]) &&
                     (cmd_wptr_q[CAW-1:0] == cmd_rptr_q[CAW-1:0]);
        resp_empty = (resp_wptr_q == resp_rptr_q);
        resp_full  = (resp_wptr_q[RAW] != resp_rptr_q[RAW]) &&
                     (resp_wptr_q[RAW-1:0] == resp_rptr_q[RAW-1:0]);

        out_zero   = (outstanding_q == '0);
        credit_ok  = (outstanding_q < MaxOut);

        // Readies come from registered pointers only; rst is folded in so
        // both readies read 0 throughout reset.
        host_cmd_ready  = !cmd_full && !rst;
        nmcu_resp_ready = !resp_full && !rst;

        cpu_instr_valid = !cmd_empty && credit_ok;
        host_resp_valid = !resp_empty;

        // Payloads read 0 whenever nothing is offered.
        cpu_instruction = cpu_instr_valid ? cmd_mem_q[cmd_rptr_q[CAW-1:0]] : '0;
        host_resp       = host_resp_valid ? resp_mem_q[resp_rptr_q[RAW-1:0]] : '0;

        cmd_push    = host_cmd_valid && host_cmd_ready;
        cmd_issue   = cpu_instr_valid && cpu_instr_ready;
        resp_accept = nmcu_resp_valid && nmcu_resp_ready;
        resp_pop    = host_resp_valid && host_resp_ready;

        outstanding    = outstanding_q;
        timeout_err    = timeout_err_q;
        stray_resp_err = stray_err_q;
    end

    // Next-state for both FIFO pointer pairs
    always_comb begin
        cmd_wptr_d  = cmd_wptr_q;
        cmd_rptr_d  = cmd_rptr_q;
        resp_wptr_d = resp_wptr_q;
        resp_rptr_d = resp_rptr_q;
        if (cmd_push) begin
            cmd_wptr_d = cmd_wptr_q + CmdOne;
        end
        if (cmd_issue) begin
            cmd_rptr_d = cmd_rptr_q + CmdOne;
        end
        if (resp_accept) begin
            resp_wptr_d = resp_wptr_q + RespOne;
        end
        if (resp_pop) begin
            resp_rptr_d = resp_rptr_q + RespOne;
        end
    end

    // Credit counter: a stray response leaves the count at 0, so an issue in
    // the same cycle still nets +1.
    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({cmd_issue, resp_accept})
            2'b10: outstanding_d = outstanding_q + OutOne;
            2'b01: begin
                if (!out_zero) begin
                    outstanding_d = outstanding_q - OutOne;
                end
            end
            2'b11: begin
                if (out_zero) begin
                    outstanding_d = outstanding_q + OutOne;
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Watchdog counter and sticky error flags; a set beats err_clr
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (resp_accept || out_zero) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WdLimit) begin
            wd_cnt_d = wd_cnt_q + WdOne;
        end

        // Flag the moment the limit is reached, not every saturated cycle,
        // so err_clr can acknowledge a long-stuck transaction.
        wd_reach = (wd_cnt_q != WdLimit) && (wd_cnt_d == WdLimit);

        timeout_err_d = wd_reach || (timeout_err_q && !err_clr);
        stray_err_d   = (resp_accept && out_zero) || (stray_err_q && !err_clr);
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wptr_q    <= '0;
            cmd_rptr_q    <= '0;
            resp_wptr_q   <= '0;
            resp_rptr_q   <= '0;
            outstanding_q <= '0;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
            stray_err_q   <= 1'b0;
        end else begin
            cmd_wptr_q    <= cmd_wptr_d;
            cmd_rptr_q    <= cmd_rptr_d;
            resp_wptr_q   <= resp_wptr_d;
            resp_rptr_q   <= resp_rptr_d;
            outstanding_q <= outstanding_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
            stray_err_q   <= stray_err_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem_q[cmd_wptr_q[CAW-1:0]] <= host_cmd;
        end
        if (resp_accept) begin
            resp_mem_q[resp_wptr_q[RAW-1:0]] <= nmcu_response;
        end
    end

endmodule

// File: tb/tb_nmcu_host_link.sv
// Randomized scoreboard bench for nmcu_host_link.
module tb_nmcu_host_link;
    import instr_pkg::*;

    localparam int unsigned CMD_DEPTH  = 4;
    localparam int unsigned RESP_DEPTH = 4;
    localparam int unsigned MAX_OUT    = 4;
    localparam int unsigned TMO        = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           host_cmd_valid, host_cmd_ready;
    instruction_t   host_cmd;
    logic           cpu_instr_valid, cpu_instr_ready;
    instruction_t   cpu_instruction;
    logic           nmcu_resp_valid, nmcu_resp_ready;
    nmcu_cpu_resp_t nmcu_response;
    logic           host_resp_valid, host_resp_ready;
    nmcu_cpu_resp_t host_resp;
    logic [2:0]     outstanding;
    logic           timeout_err, stray_resp_err, err_clr;

    nmcu_host_link #(
        .CMD_DEPTH       (CMD_DEPTH),
        .RESP_DEPTH      (RESP_DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .host_cmd_valid  (host_cmd_valid),
        .host_cmd_ready  (host_cmd_ready),
        .host_cmd        (host_cmd),
        .cpu_instr_valid (cpu_instr_valid),
        .cpu_instr_ready (cpu_instr_ready),
        .cpu_instruction (cpu_instruction),
        .nmcu_resp_valid (nmcu_resp_valid),
        .nmcu_resp_ready (nmcu_resp_ready),
        .nmcu_response   (nmcu_response),
        .host_resp_valid (host_resp_valid),
        .host_resp_ready (host_resp_ready),
        .host_resp       (host_resp),
        .outstanding     (outstanding),
        .timeout_err     (timeout_err),
        .stray_resp_err  (stray_resp_err),
        .err_clr         (err_clr)
    );

    int vectors = 0;
    int fails   = 0;

    // Reference model: what the link should hold, as plain queues and counts.
    instruction_t   cmd_q  [$];
    nmcu_cpu_resp_t resp_q [$];
    int             m_out;
    int             m_since;
    bit             m_tmo;
    bit             m_stray;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic nmcu_cpu_resp_t rand_resp();
        nmcu_cpu_resp_t r;
        r.tag    = 8'($urandom());
        r.status = 2'($urandom());
        r.data   = $urandom();
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".host_cmd_ready"},  host_cmd_ready,  0);
        check({tag, ".cpu_instr_valid"}, cpu_instr_valid, 0);
        check({tag, ".cpu_instruction"}, cpu_instruction, 0);
        check({tag, ".nmcu_resp_ready"}, nmcu_resp_ready, 0);
        check({tag, ".host_resp_valid"}, host_resp_valid, 0);
        check({tag, ".host_resp"},       host_resp,       0);
        check({tag, ".outstanding"},     outstanding,     0);
        check({tag, ".timeout_err"},     timeout_err,     0);
        check({tag, ".stray_resp_err"},  stray_resp_err,  0);
    endtask

    // Monitor: compares DUT state with the model, then advances the model by
    // the handshakes that will complete on the coming rising edge.
    always @(negedge clk) begin
        bit push, issue, racc, drain, stray, reach;
        instruction_t   exp_cmd;
        nmcu_cpu_resp_t exp_resp;
        if (rst) begin
            cmd_q.delete();
            resp_q.delete();
            m_out   = 0;
            m_since = 0;
            m_tmo   = 0;
            m_stray = 0;
        end else begin
            check("host_cmd_ready",  host_cmd_ready,  cmd_q.size() < CMD_DEPTH);
            check("cpu_instr_valid", cpu_instr_valid, cmd_q.size() > 0 && m_out < MAX_OUT);
            check("nmcu_resp_ready", nmcu_resp_ready, resp_q.size() < RESP_DEPTH);
            check("host_resp_valid", host_resp_valid, resp_q.size() > 0);
            check("outstanding",     outstanding,     m_out);
            check("timeout_err",     timeout_err,     m_tmo);
            check("stray_resp_err",  stray_resp_err,  m_stray);

            push  = host_cmd_valid && host_cmd_ready;
            issue = cpu_instr_valid && cpu_instr_ready;
            racc  = nmcu_resp_valid && nmcu_resp_ready;
            drain = host_resp_valid && host_resp_ready;

            if (issue) begin
                if (cmd_q.size() == 0) begin
                    check("issue_with_no_command", 1, 0);
                end else begin
                    exp_cmd = cmd_q.pop_front();
                    check("cpu_instruction", cpu_instruction, exp_cmd);
                end
            end
            if (drain) begin
                if (resp_q.size() == 0) begin
                    check("drain_with_no_response", 1, 0);
                end else begin
                    exp_resp = resp_q.pop_front();
                    check("host_resp", host_resp, exp_resp);
                end
            end
            if (push) cmd_q.push_back(host_cmd);
            if (racc) resp_q.push_back(nmcu_response);

            // Watchdog: cycles spent with work in flight since the last response.
            reach = 0;
            if (racc || m_out == 0) begin
                m_since = 0;
            end else if (m_since < TMO) begin
                m_since++;
                reach = (m_since == TMO);
            end

            stray   = racc && m_out == 0;
            m_tmo   = reach || (m_tmo && !err_clr);
            m_stray = stray || (m_stray && !err_clr);
            m_out   = m_out + int'(issue) - int'(racc && !stray);
        end
    end

    task automatic push_cmds(input int attempts, output int accepted);
        accepted = 0;
        for (int i = 0; i < attempts; i++) begin
            host_cmd_valid = 1'b1;
            host_cmd       = $urandom();
            if (host_cmd_ready) accepted++;
            tick();
        end
        host_cmd_valid = 1'b0;
    endtask

    task automatic send_resp();
        nmcu_resp_valid = 1'b1;
        nmcu_response   = rand_resp();
        for (int i = 0; i < 64; i++) begin
            if (nmcu_resp_ready) break;
            tick();
        end
        if (!nmcu_resp_ready) check("resp_accept_bound", 0, 1);
        tick();
        nmcu_resp_valid = 1'b0;
    endtask

    task automatic randomize_inputs();
        host_cmd_valid  = ($urandom_range(0, 99) < 50);
        host_cmd        = $urandom();
        cpu_instr_ready = ($urandom_range(0, 99) < 60);
        nmcu_resp_valid = ($urandom_range(0, 99) < 35) &&
                          (outstanding != 0 || $urandom_range(0, 19) == 0);
        nmcu_response   = rand_resp();
        host_resp_ready = ($urandom_range(0, 99) < 70);
        err_clr         = ($urandom_range(0, 99) < 3);
    endtask

    initial begin
        int acc;
        rst             = 1'b1;
        host_cmd_valid  = 1'b0;
        host_cmd        = '0;
        cpu_instr_ready = 1'b0;
        nmcu_resp_valid = 1'b0;
        nmcu_response   = '0;
        host_resp_ready = 1'b0;
        err_clr         = 1'b0;

        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;

        // Single round trip
        cpu_instr_ready = 1'b1;
        host_resp_ready = 1'b1;
        push_cmds(1, acc);
        repeat (2) tick();
        send_resp();
        repeat (3) tick();

        // Credit limit: six commands, no responses
        push_cmds(6, acc);
        check("credit_pushes", acc, 6);
        repeat (6) tick();
        check("credit_outstanding", outstanding, MAX_OUT);
        check("credit_valid_low", cpu_instr_valid, 0);
        for (int i = 0; i < 6; i++) begin
            send_resp();
            repeat (2) tick();
        end

        // Command backpressure
        cpu_instr_ready = 1'b0;
        push_cmds(5, acc);
        check("backpressure_pushes", acc, CMD_DEPTH);
        check("backpressure_ready_low", host_cmd_ready, 0);
        repeat (3) tick();
        cpu_instr_ready = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < 4; i++) send_resp();
        repeat (3) tick();

        // Response FIFO full (stray responses, outstanding is 0)
        host_resp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            nmcu_resp_valid = 1'b1;
            nmcu_response   = rand_resp();
            if (nmcu_resp_ready) acc++;
            tick();
        end
        nmcu_resp_valid = 1'b0;
        check("respfull_accepts", acc, RESP_DEPTH);
        check("respfull_ready_low", nmcu_resp_ready, 0);
        check("respfull_stray", stray_resp_err, 1);
        host_resp_ready = 1'b1;
        repeat (6) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();

        // Watchdog
        push_cmds(1, acc);
        repeat (TMO + 4) tick();
        check("wd_timeout_set", timeout_err, 1);
        send_resp();
        tick();
        check("wd_kept_after_resp", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        check("wd_cleared", timeout_err, 0);

        // Stray response
        send_resp();
        tick();
        check("stray_set", stray_resp_err, 1);
        repeat (2) tick();

        // Random traffic, with a reset landing mid-stream
        for (int i = 0; i < 1500; i++) begin
            randomize_inputs();
            tick();
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero("midreset");
        tick();
        tick();
        check_zero("midreset_hold");
        rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            randomize_inputs();
            tick();
        end

        // Quiesce
        host_cmd_valid  = 1'b0;
        nmcu_resp_valid = 1'b0;
        cpu_instr_ready = 1'b1;
        host_resp_ready = 1'b1;
        err_clr         = 1'b0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/nmcu_host_link.md
# nmcu_host_link

Host-side end of the CPU–NMCU chiplet link. It accepts instructions from a CPU-side requester, buffers them, and issues them to the NMCU over the `cpu_instr_*` handshake, limiting the number in flight with a credit count. It collects NMCU responses over the `nmcu_resp_*` handshake, buffers them back to the requester, and runs a response watchdog. It sits in the CPU die / testbench driver layer, opposite the NMCU's interconnect interface.

## Interface
- `CMD_DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `RESP_DEPTH`, 4: response FIFO entries; power of 2, ≥2.
- `MAX_OUTSTANDING`, 4: maximum issued instructions without a response, ≥1.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in cycles, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `host_cmd_valid`  in  1  requester has an instruction.
- `host_cmd_ready`  out  1  command FIFO not full.
- `host_cmd`  in  `instr_pkg::instruction_t`  instruction from the requester.
- `cpu_instr_valid`  out  1  instruction offered to the NMCU.
- `cpu_instr_ready`  in  1  NMCU accepts.
- `cpu_instruction`  out  `instr_pkg::instruction_t`  head of the command FIFO.
- `nmcu_resp_valid`  in  1  NMCU response offered.
- `nmcu_resp_ready`  out  1  response FIFO not full.
- `nmcu_response`  in  `instr_pkg::nmcu_cpu_resp_t`  response payload.
- `host_resp_valid`  out  1  response available to the requester.
- `host_resp_ready`  in  1  requester accepts.
- `host_resp`  out  `instr_pkg::nmcu_cpu_resp_t`  head of the response FIFO.
- `outstanding`  out  `$clog2(MAX_OUTSTANDING+1)`  instructions in flight.
- `timeout_err`  out  1  sticky watchdog error.
- `stray_resp_err`  out  1  sticky flag for a response received while `outstanding == 0`.
- `err_clr`  in  1  synchronous clear of both sticky flags.

## Operation
- **Command push:** occurs when `host_cmd_valid && host_cmd_ready`. Writes the FIFO tail.
- **Issue:**
  - `cpu_instr_valid = cmd_not_empty && (outstanding < MAX_OUTSTANDING)`.
  - `cpu_instruction` is the FIFO head.
  - A handshake (`valid && ready`) pops the head and increments `outstanding`.
  - Once asserted, `valid` and the payload are held until the handshake; no withdrawal. Credit cannot drop while valid is high.
- **Response accept:**
  - `nmcu_resp_ready = resp_not_full`, independent of credit.
  - A handshake writes the response FIFO and decrements `outstanding`.
  - If `outstanding == 0` at that point, the response is still buffered, `outstanding` stays 0, and `stray_resp_err` is set.
- **Simultaneous issue and response accept:** `outstanding` is unchanged (unless stray: then +1).
- **Response drain:** `host_resp_valid = resp_not_empty`. `host_resp` is the head; it is popped on handshake.
- **FIFO rules:** simultaneous push and pop on a non-empty, non-full FIFO is legal and the count is unchanged. Pointers wrap modulo depth, with one extra bit distinguishing full from empty.
- **Watchdog:**
  - The counter clears on reset, on any response accept, and whenever `outstanding == 0`.
  - Otherwise it increments each cycle, saturating at `TIMEOUT_CYCLES`.
  - Reaching `TIMEOUT_CYCLES` sets `timeout_err`.
- **Sticky flags:** `err_clr` clears both. A set event in the same cycle wins over the clear.

## Timing
- **Reset:** all outputs are 0 while `rst` is high, including both ready outputs. FIFOs flush, counters clear, and in-flight transactions are discarded.
- **First cycle after reset release:** `host_cmd_ready = 1`, `nmcu_resp_ready = 1`.
- **Reset asserted mid-transfer:** outputs drop asynchronously. No partial state survives.
- **Latency, command:** pushed in cycle N → `cpu_instr_valid` high in cycle N+1 (empty FIFO, credit available).
- **Latency, response:** accepted in cycle N → `host_resp_valid` high in cycle N+1.
- **Ready timing:** `host_cmd_ready` and `nmcu_resp_ready` are derived only from registered FIFO state, with no combinational path from any input. A pop does not free space for a push in the same cycle while full.
- **Full-rate streaming:** 1 instruction per cycle is sustained when credit and FIFO space allow.
- **Outstanding update:** `outstanding` changes on the clock edge following the handshake.

## Test plan
- **Single round trip:** reset, push one instruction, NMCU ready high, one response 3 cycles later → `cpu_instr_valid` in cycle 1, `outstanding` goes 1 then 0, `host_resp_valid` 1 cycle after the response handshake, payloads match.
- **Credit limit:** push 6 instructions with `MAX_OUTSTANDING = 4` and no responses → exactly 4 issues, `cpu_instr_valid = 0`, `outstanding = 4`. Each response releases exactly one further issue.
- **Backpressure:** hold `cpu_instr_ready = 0`, push 5 with `CMD_DEPTH = 4` → `host_cmd_ready = 0` after 4 pushes. `cpu_instruction` stays stable while valid; releasing ready drains in order.
- **Response FIFO full:** hold `host_resp_ready = 0`, send 5 responses → `nmcu_resp_ready = 0` after 4. Order is preserved on drain.
- **Watchdog:** issue 1, no response, `TIMEOUT_CYCLES = 16` → `timeout_err` rises exactly 16 cycles after the issue edge. A response arriving does not clear it; `err_clr` does.
- **Stray response and reset:** response with `outstanding = 0` → `stray_resp_err = 1` and the response is forwarded. Assert `rst` mid-stream → all outputs 0 and FIFOs empty.
